pipe_delay_line: RTL and testbench
==================================

// Module: pipe_delay_line
// PURPOSE
//  Parametrised multi-stage pipeline register chain with per-stage valid bits,
//  global stall (hold) and flush (kill) controls. It carries any pipeline payload
//  (ALU result, PC, control word) across DEPTH clock edges between stages.
//  It generalises the single-register ALU buffer stages: width, depth and
//  hazard control are configurable. Sits between EX/MEM/WB stage logic.
// PARAMETERS
//  WIDTH      32   payload width in bits (>=1)
//  DEPTH      2    number of register stages = latency in cycles (>=1)
//  RESET_VAL  '0   value loaded into every data register on reset/flush
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 reset, asynchronous, active-high
//  stall_i      in   1                 1 = all stages hold contents this cycle
//  flush_i      in   1                 1 = kill all stages at next edge
//  valid_i      in   1                 payload on data_i is valid
//  data_i       in   WIDTH             payload into stage 0
//  valid_o      out  1                 valid bit of stage DEPTH-1
//  data_o       out  WIDTH             data of stage DEPTH-1
//  occupancy_o  out  $clog2(DEPTH+1)   number of stages holding valid=1
//  tap_valid_o  out  DEPTH             per-stage valid (PIPE_TAP_EN only)
//  tap_data_o   out  DEPTH x WIDTH     per-stage data  (PIPE_TAP_EN only)
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation): all valid=0, all data=RESET_VAL;
//    so valid_o=0, data_o=RESET_VAL, occupancy_o=0 while rst high and after release.
//  - Advance (stall_i=0, flush_i=0): stage0 <= {valid_i,data_i};
//    stage k <= stage k-1 for k=1..DEPTH-1. Data loads regardless of valid.
//  - Latency: valid_i/data_i at edge N appear on valid_o/data_o after edge N+DEPTH-1
//    (i.e. DEPTH edges of capture), absent stall/flush.
//  - Stall (stall_i=1, flush_i=0): every stage holds; valid_i/data_i ignored (input
//    lost; upstream must also hold). Outputs unchanged.
//  - Flush (flush_i=1): at next edge all valid=0, all data=RESET_VAL. Flush beats stall.
//    valid_i in the same cycle is discarded.
//  - Bubbles: valid_i=0 propagates as valid=0 stage; data still shifts.
//  - occupancy_o: registered-state popcount of stage valids (combinational from
//    flops, no extra latency); range 0..DEPTH.
//  - DEPTH=1: single register plus valid, same stall/flush rules.
//  - No X propagation: outputs defined every cycle after reset.
// CONFIGURATION
//  - Macro PIPE_TAP_EN defined: tap_valid_o[k]/tap_data_o[k] expose stage k contents
//    (k=0 newest) for hazard detection/forwarding logic.
//  - Macro undefined: tap ports absent from the port list; no extra logic.
// STRUCTURE
//  - Package riscv_pipe_pkg: XLEN=32 constant, typedef pipe_word_t (logic [XLEN-1:0]),
//    typedef pipe_ctl_t struct {stall, flush} shared with hazard unit.
//  - Sub-module pipe_stage: one {valid,data} register with en (advance), clr (flush),
//    async rst; pipe_delay_line instantiates DEPTH of them via generate loop.
//  - Occupancy popcount: combinational loop in top level.
// TESTING
//  1 rst high mid-stream with DEPTH=3 full -> valid_o=0, data_o=RESET_VAL,
//    occupancy_o=0 within same cycle (before next edge).
//  2 DEPTH=2, drive 0xA5A5_0001 valid at edge 1 then valid_i=0 -> data_o=0xA5A5_0001,
//    valid_o=1 after edge 2 only; valid_o=0 after edge 3.
//  3 Stream 1,2,3 (DEPTH=2), stall_i=1 for 2 cycles after value 2 enters -> data_o
//    holds 1, occupancy_o=2 during stall; value 3 presented during stall lost;
//    resumes with 2 after release.
//  4 Pipe full (occupancy 2), flush_i=1 and stall_i=1 together -> next edge all
//    valid=0, occupancy_o=0, data_o=RESET_VAL.
//  5 Alternate valid_i 1/0 with data 0x10,0x11,... DEPTH=4 -> valid_o toggles 1/0
//    after 4-edge latency, occupancy_o steady 2.
//  6 PIPE_TAP_EN build, DEPTH=3, push 0x1,0x2,0x3 -> tap_data_o = {0x3,0x2,0x1}
//    for stages 0..2, tap_valid_o=3'b111; undefined build elaborates without tap ports.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: machine word and the stall/flush control bundle
// driven by the hazard unit.
package riscv_pipe_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] pipe_word_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_stage.sv
// One {valid,data} pipeline register: async reset, synchronous clear (flush)
// with priority over enable (advance).
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (clr) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_delay_line.sv
// DEPTH-stage payload delay line with per-stage valid, global stall and flush.
// Define PIPE_TAP_EN to expose every stage on tap_valid_o / tap_data_o.
module pipe_delay_line
  import riscv_pipe_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
`ifdef PIPE_TAP_EN
  output logic [DEPTH-1:0]           tap_valid_o,
  output logic [DEPTH-1:0][WIDTH-1:0] tap_data_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH+1);

  pipe_ctl_t ctl;
  assign ctl.stall = stall_i;
  assign ctl.flush = flush_i;

  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH-1:0][WIDTH-1:0] stage_data;

  // Stage 0 is the newest entry; stage DEPTH-1 drives the outputs.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             valid_d;
    logic [WIDTH-1:0] data_d;

    if (k == 0) begin : g_head
      assign valid_d = valid_i;
      assign data_d  = data_i;
    end else begin : g_body
      assign valid_d = stage_valid[k-1];
      assign data_d  = stage_data[k-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (~ctl.stall),
      .clr     (ctl.flush),
      .valid_d (valid_d),
      .data_d  (data_d),
      .valid_q (stage_valid[k]),
      .data_q  (stage_data[k])
    );
  end

  assign valid_o = stage_valid[DEPTH-1];
  assign data_o  = stage_data[DEPTH-1];

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy_o = occupancy_o + OCC_W'(stage_valid[k]);
    end
  end

`ifdef PIPE_TAP_EN
  assign tap_valid_o = stage_valid;
  assign tap_data_o  = stage_data;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed-vector bench for pipe_delay_line at DEPTH 1..4; tap checks run
// only when PIPE_TAP_EN is defined.
module tb_pipe_delay_line;
  import riscv_pipe_pkg::*;

  localparam logic [31:0] RV3 = 32'hDEAD_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  pipe_word_t data_i  = '0;

  logic v1, v2, v3, v4;
  pipe_word_t d1, d2, d3, d4;
  logic       o1;
  logic [1:0] o2, o3;
  logic [2:0] o4;
`ifdef PIPE_TAP_EN
  logic [0:0]            tv1;
  logic [1:0]            tv2;
  logic [2:0]            tv3;
  logic [3:0]            tv4;
  logic [0:0][31:0]      td1;
  logic [1:0][31:0]      td2;
  logic [2:0][31:0]      td3;
  logic [3:0][31:0]      td4;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_delay_line #(.DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .valid_o(v1), .data_o(d1),
`ifdef PIPE_TAP_EN
    .tap_valid_o(tv1), .tap_data_o(td1),
`endif
    .occupancy_o(o1));

  pipe_delay_line #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .valid_o(v2), .data_o(d2),
`ifdef PIPE_TAP_EN
    .tap_valid_o(tv2), .tap_data_o(td2),
`endif
    .occupancy_o(o2));

  pipe_delay_line #(.DEPTH(3), .RESET_VAL(RV3)) u3 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .valid_o(v3), .data_o(d3),
`ifdef PIPE_TAP_EN
    .tap_valid_o(tv3), .tap_data_o(td3),
`endif
    .occupancy_o(o3));

  pipe_delay_line #(.DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .valid_o(v4), .data_o(d4),
`ifdef PIPE_TAP_EN
    .tap_valid_o(tv4), .tap_data_o(td4),
`endif
    .occupancy_o(o4));

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [31:0] d);
    valid_i = v;
    data_i  = d;
    step();
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    valid_i = 1'b0;
    step();
    flush_i = 1'b0;
  endtask

  initial begin
    // reset state
    #1 rst = 1'b1;
    #2;
    check_vec("rst_v2", 64'(v2), 64'd0);
    check_vec("rst_d2", 64'(d2), 64'd0);
    check_vec("rst_o2", 64'(o2), 64'd0);
    check_vec("rst_d3", 64'(d3), 64'(RV3));
    step();
    rst = 1'b0;
    step();
    check_vec("post_rst_o4", 64'(o4), 64'd0);
    check_vec("post_rst_v1", 64'(v1), 64'd0);

    // single valid word through DEPTH=2, then bubbles
    push(1'b1, 32'hA5A5_0001);
    valid_i = 1'b0;
    data_i  = '0;
    check_vec("lat_e1_v", 64'(v2), 64'd0);
    step();
    check_vec("lat_e2_v", 64'(v2), 64'd1);
    check_vec("lat_e2_d", 64'(d2), 64'hA5A5_0001);
    step();
    check_vec("lat_e3_v", 64'(v2), 64'd0);
    check_vec("lat_e3_d", 64'(d2), 64'd0);

    // stall holds contents, input during stall is lost
    do_flush();
    push(1'b1, 32'd1);
    push(1'b1, 32'd2);
    check_vec("pre_stall_d", 64'(d2), 64'd1);
    stall_i = 1'b1;
    push(1'b1, 32'd3);
    check_vec("stall1_d", 64'(d2), 64'd1);
    check_vec("stall1_o", 64'(o2), 64'd2);
    push(1'b1, 32'd3);
    check_vec("stall2_d", 64'(d2), 64'd1);
    check_vec("stall2_v", 64'(v2), 64'd1);
    check_vec("stall2_o", 64'(o2), 64'd2);
    stall_i = 1'b0;
    push(1'b0, 32'd0);
    check_vec("resume_d", 64'(d2), 64'd2);
    check_vec("resume_v", 64'(v2), 64'd1);
    check_vec("resume_o", 64'(o2), 64'd1);
    step();
    check_vec("lost3_d", 64'(d2), 64'd0);
    check_vec("lost3_v", 64'(v2), 64'd0);

    // flush beats stall
    push(1'b1, 32'd7);
    push(1'b1, 32'd8);
    check_vec("full_o2", 64'(o2), 64'd2);
    stall_i = 1'b1;
    flush_i = 1'b1;
    push(1'b1, 32'd9);
    stall_i = 1'b0;
    flush_i = 1'b0;
    check_vec("flush_v2", 64'(v2), 64'd0);
    check_vec("flush_o2", 64'(o2), 64'd0);
    check_vec("flush_d2", 64'(d2), 64'd0);
    check_vec("flush_d3", 64'(d3), 64'(RV3));
    check_vec("flush_o4", 64'(o4), 64'd0);

    // alternating valid through DEPTH=4
    for (int i = 0; i < 12; i++) begin
      push((i % 2) == 0, 32'h10 + 32'(i));
      if (i >= 3) begin
        check_vec("alt_v", 64'(v4), 64'(((i - 3) % 2) == 0));
        check_vec("alt_d", 64'(d4), 64'(32'h10 + 32'(i - 3)));
      end
      if (i >= 2) check_vec("alt_o", 64'(o4), 64'd2);
    end

    // DEPTH=1
    do_flush();
    push(1'b1, 32'h55);
    check_vec("d1_v", 64'(v1), 64'd1);
    check_vec("d1_d", 64'(d1), 64'h55);
    check_vec("d1_o", 64'(o1), 64'd1);
    stall_i = 1'b1;
    push(1'b0, 32'h66);
    stall_i = 1'b0;
    check_vec("d1_stall_d", 64'(d1), 64'h55);
    check_vec("d1_stall_v", 64'(v1), 64'd1);
    do_flush();
    check_vec("d1_flush_v", 64'(v1), 64'd0);

    // DEPTH=3 fill, taps, then async reset mid-stream
    push(1'b1, 32'h1);
    push(1'b1, 32'h2);
    push(1'b1, 32'h3);
    valid_i = 1'b0;
    check_vec("fill_o3", 64'(o3), 64'd3);
    check_vec("fill_d3", 64'(d3), 64'h1);
`ifdef PIPE_TAP_EN
    check_vec("tap_v", 64'(tv3), 64'b111);
    check_vec("tap_d0", 64'(td3[0]), 64'h3);
    check_vec("tap_d1", 64'(td3[1]), 64'h2);
    check_vec("tap_d2", 64'(td3[2]), 64'h1);
`endif
    #2 rst = 1'b1;
    #1;
    check_vec("arst_v3", 64'(v3), 64'd0);
    check_vec("arst_d3", 64'(d3), 64'(RV3));
    check_vec("arst_o3", 64'(o3), 64'd0);
    step();
    rst = 1'b0;
    step();
    check_vec("after_arst_o3", 64'(o3), 64'd0);
    check_vec("after_arst_v3", 64'(v3), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
